elevator_call_panel: RTL
========================

Name: elevator_call_panel

Overview:
Request-side partner of elevetor_controller. It latches floor call-button presses and schedules them in SCAN order, nearest pending floor in the current travel direction first. It drives one one-hot floor_req at a time into the controller and watches floor_pos to detect arrival. It holds each request through a dwell period, then retires it, and flags a fault if the controller never arrives.

Parameters:
N_FLOORS, 5, number of floors; width of btn, floor_pos, floor_req and pending
DWELL_CYCLES, 4, cycles floor_req is held after arrival before the request retires (min 1)
TIMEOUT_CYCLES, 64, cycles allowed in WAIT before the request is abandoned (min 2)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
btn  input  N_FLOORS  call buttons, synchronous to clk, level; bit i = floor i+1
floor_pos  input  N_FLOORS  one-hot current car floor from controller; 0 or multi-hot = between floors/invalid
floor_req  output  N_FLOORS  one-hot request to controller; 0 = no request
pending  output  N_FLOORS  latched outstanding calls (button lamps)
dir_up  output  1  current scan direction (1 = up)
busy  output  1  high whenever FSM not in IDLE
fault  output  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous): pending=0, floor_req=0, btn_q=0, dir_up=1, busy=0, fault=0, timer=0, dwell count=0, cur_q=0 (floor 1), state=IDLE.
- Edge capture: rise[i] = btn[i] & ~btn_q[i]; btn_q <= btn every cycle.
- pending[i] is set on the edge where rise[i]=1. A held button sets it only once.
- Exception: a press for the floor equal to cur_q is ignored while in IDLE or DWELL.
- If set and clear hit the same bit in the same cycle, clear wins.
- Position tracking: cur_q <= index of floor_pos when floor_pos is exactly one-hot. Otherwise cur_q holds its value.
- Target selection: combinational from registered pending and cur_q.
  - dir_up=1: lowest pending index > cur_q. If none, highest pending index < cur_q, and dir_up flips to 0 on the IDLE->ISSUE transition.
  - dir_up=0: mirror of the above.
  - No target if pending is 0 or only pending[cur_q] is set.
- FSM states: IDLE, ISSUE, WAIT, DWELL.
  - IDLE: floor_req=0. If a target exists, latch tgt and go to ISSUE. pending[cur_q] is cleared if set.
  - ISSUE (1 cycle): floor_req <= onehot(tgt); timer <= 0; go to WAIT.
  - WAIT: floor_req held stable and timer increments.
    - If floor_pos == floor_req: go to DWELL, dwell count <= 0.
    - Else if timer == TIMEOUT_CYCLES-1: fault <= 1, pending[tgt] <= 0, floor_req <= 0, go to IDLE.
    - Arrival wins if both conditions are true in the same cycle.
  - DWELL: floor_req held. Count DWELL_CYCLES cycles; on the last one: pending[tgt] <= 0, floor_req <= 0, go to IDLE.
- No preemption: presses for other floors during ISSUE, WAIT or DWELL only set pending; tgt is unchanged.
- A press for tgt during WAIT or DWELL has no extra effect. That bit is cleared at retire.
- Latency: with btn[i] rising sampled at edge k, pending[i]=1 after k, state=ISSUE after k+1, floor_req valid after k+2.
- Minimum request cycle with immediate arrival: ISSUE 1 + WAIT 1 + DWELL DWELL_CYCLES, then 1 IDLE cycle between consecutive requests.
- busy = (state != IDLE).
- fault stays 1 until reset; the FSM keeps servicing further requests normally.
- Reset mid-operation clears everything at once; floor_req goes to 0 asynchronously.

Test Plan:
1. Reset, floor_pos=00001, press btn=00100 for 1 cycle -> pending=00100 after edge k, floor_req=00100 at k+2. Drive floor_pos=00100 -> floor_req held 4 cycles, then floor_req=00000 and pending=00000.
2. cur=floor 3, dir_up=1, press 00010 and 10000 together -> floor_req=10000 first. After retire, dir_up=0 and floor_req=00010.
3. floor_pos held 00001 and never reaches 01000 -> after 64 WAIT cycles: fault=1, pending[3]=0, floor_req=0. A later request is still serviced and fault stays 1.
4. While in WAIT for 00100, press 00001 -> floor_req stays 00100 and pending=00101. 00001 is issued after retire.
5. Hold btn=01000 for 20 cycles -> exactly one request issued. Press the current floor while IDLE -> pending unchanged, busy=0.
6. Assert reset=0 mid-DWELL -> same cycle, floor_req=0 and pending=0. After release: busy=0, dir_up=1, fault=0.

Source files
------------

// File: rtl/elevator_call_panel.sv
// elevator_call_panel
// Request side of the elevator pair. Latches call-button presses into a
// pending set, picks the next floor in SCAN order (nearest pending floor in
// the current travel direction, reversing only when nothing is ahead), and
// presents it to the car controller as a one-hot floor_req. The request is
// held through arrival plus a dwell period and then retired. If the car never
// arrives within the timeout, the request is dropped and a sticky fault is
// raised.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   btn        call buttons, level, bit i = floor i+1
//   floor_pos  one-hot car position (0 / multi-hot = between floors)
//   floor_req  one-hot request to the car controller, 0 = none
//   pending    outstanding calls (button lamps)
//   dir_up     current scan direction, 1 = up
//   busy       FSM is not idle
//   fault      sticky timeout flag
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no request out; clear call at current floor, pick next target
// S_ISSUE | one cycle: drive floor_req for the latched target, clear timer
// S_WAIT  | request out, waiting for floor_pos to match; timeout counting
// S_DWELL | car arrived; hold request for DWELL_CYCLES, then retire

module elevator_call_panel #(
    parameter int N_FLOORS       = 5,
    parameter int DWELL_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] btn,
    input  logic [N_FLOORS-1:0] floor_pos,
    output logic [N_FLOORS-1:0] floor_req,
    output logic [N_FLOORS-1:0] pending,
    output logic                dir_up,
    output logic                busy,
    output logic                fault
);

    localparam int CW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DWELL} state_t;

    state_t              state, state_n;
    logic [N_FLOORS-1:0] btn_q, rise, set_mask, clr_mask, pending_n, floor_req_n;
    logic [N_FLOORS-1:0] cur_bit, tgt_bit;
    logic [CW-1:0]       cur_q, cur_n, pos_idx, tgt, tgt_n;
    logic [CW-1:0]       up_idx, dn_idx, sel_idx;
    logic                up_found, dn_found, sel_found, sel_flip;
    logic [TW-1:0]       timer, timer_n;
    logic [DW-1:0]       dwell, dwell_n;
    logic                dir_up_n, fault_n;

    assign rise    = btn & ~btn_q;
    assign cur_bit = N_FLOORS'(1) << cur_q;
    assign tgt_bit = N_FLOORS'(1) << tgt;
    assign busy    = (state != S_IDLE);

    // Position only updates on a clean one-hot reading; between floors the
    // last known floor is kept.
    always_comb begin
        pos_idx = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (floor_pos[i]) pos_idx = CW'(i);
        end
        cur_n = $onehot(floor_pos) ? pos_idx : cur_q;
    end

    // Nearest pending floor above and below the current floor.
    always_comb begin
        up_found = 1'b0;
        up_idx   = '0;
        dn_found = 1'b0;
        dn_idx   = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_q))) begin
                up_found = 1'b1;
                up_idx   = CW'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (i < int'(cur_q))) begin
                dn_found = 1'b1;
                dn_idx   = CW'(i);
            end
        end
        sel_found = up_found | dn_found;
        sel_flip  = 1'b0;
        if (dir_up) begin
            sel_idx  = up_found ? up_idx : dn_idx;
            sel_flip = ~up_found & dn_found;
        end else begin
            sel_idx  = dn_found ? dn_idx : up_idx;
            sel_flip = ~dn_found & up_found;
        end
    end

    always_comb begin
        state_n     = state;
        tgt_n       = tgt;
        floor_req_n = floor_req;
        timer_n     = timer;
        dwell_n     = dwell;
        dir_up_n    = dir_up;
        fault_n     = fault;
        set_mask    = rise;
        clr_mask    = '0;
        case (state)
            S_IDLE: begin
                // The car is already at cur_q, so a call there is served on
                // the spot rather than queued.
                set_mask    = rise & ~cur_bit;
                clr_mask    = cur_bit;
                floor_req_n = '0;
                if (sel_found) begin
                    tgt_n   = sel_idx;
                    state_n = S_ISSUE;
                    if (sel_flip) dir_up_n = ~dir_up;
                end
            end
            S_ISSUE: begin
                floor_req_n = tgt_bit;
                timer_n     = '0;
                state_n     = S_WAIT;
            end
            S_WAIT: begin
                timer_n = timer + 1'b1;
                if (floor_pos == floor_req) begin
                    dwell_n = '0;
                    state_n = S_DWELL;
                end else if (timer == TIMER_LAST) begin
                    fault_n     = 1'b1;
                    clr_mask    = tgt_bit;
                    floor_req_n = '0;
                    state_n     = S_IDLE;
                end
            end
            S_DWELL: begin
                set_mask = rise & ~cur_bit;
                dwell_n  = dwell + 1'b1;
                if (dwell == DWELL_LAST) begin
                    clr_mask    = tgt_bit;
                    floor_req_n = '0;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Clear has priority over a same-cycle press.
        pending_n = (pending | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            btn_q     <= '0;
            pending   <= '0;
            floor_req <= '0;
            cur_q     <= '0;
            tgt       <= '0;
            timer     <= '0;
            dwell     <= '0;
            dir_up    <= 1'b1;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            btn_q     <= btn;
            pending   <= pending_n;
            floor_req <= floor_req_n;
            cur_q     <= cur_n;
            tgt       <= tgt_n;
            timer     <= timer_n;
            dwell     <= dwell_n;
            dir_up    <= dir_up_n;
            fault     <= fault_n;
        end
    end

endmodule
